// File: rtl/contador_de_programa_aninhado_pkg.sv
// Shared defaults and types for the iZero nested-interrupt program counter.
package contador_de_programa_aninhado_pkg;

  localparam int unsigned IzAddrW     = 26;
  localparam int unsigned IzDepth     = 4;
  localparam int unsigned IzNVec      = 4;
  localparam int unsigned IzVecBase   = 0;
  localparam int unsigned IzVecStride = 16;

  // Per-cycle PC action chosen by the priority decode.
  typedef enum logic [1:0] {
    ActHold,
    ActNormal,
    ActPush,
    ActPop
  } pc_act_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_de_programa_aninhado_if.sv
// Control/status bundle between the interrupt controller / fetch logic and the PC.
interface contador_de_programa_aninhado_if
  import contador_de_programa_aninhado_pkg::*;
#(
  parameter int unsigned AddrW = IzAddrW,
  parameter int unsigned Depth = IzDepth,
  parameter int unsigned NVec  = IzNVec
) ();

  localparam int unsigned VecW = idx_width(NVec);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic             en;
  logic             inta;
  logic [VecW-1:0]  inta_vec;
  logic             reti;
  logic             err_clr;
  logic [AddrW-1:0] addrin;
  logic [AddrW-1:0] addrout;
  logic [AddrW-1:0] addrbckp;
  logic [LvlW-1:0]  nivel;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output en, inta, inta_vec, reti, err_clr, addrin,
    input  addrout, addrbckp, nivel, full, empty, ovf, unf
  );

  modport slave (
    input  en, inta, inta_vec, reti, err_clr, addrin,
    output addrout, addrbckp, nivel, full, empty, ovf, unf
  );

endinterface

// File: rtl/contador_de_programa_aninhado_pilha_retorno.sv
// Return-address LIFO; vacated entries are cleared on pop. Push and pop never coincide.
module pilha_retorno #(
  parameter int unsigned W     = 26,
  parameter int unsigned Depth = 4,
  localparam int unsigned LvlW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [W-1:0]    data_i,
  output logic [W-1:0]    top_o,
  output logic [LvlW-1:0] nivel_o
);

  logic [W-1:0]    mem_q [Depth];
  logic [W-1:0]    mem_d [Depth];
  logic [LvlW-1:0] nivel_q, nivel_d;

  always_comb begin
    mem_d   = mem_q;
    nivel_d = nivel_q;
    top_o   = '0;
    // Per-entry compare keeps indexing in range for any Depth.
    for (int i = 0; i < Depth; i++) begin
      if (push_i && nivel_q == LvlW'(i))     mem_d[i] = data_i;
      if (pop_i  && nivel_q == LvlW'(i + 1)) mem_d[i] = '0;
      if (nivel_q == LvlW'(i + 1))           top_o    = mem_q[i];
    end
    if (push_i)     nivel_d = nivel_q + LvlW'(1);
    else if (pop_i) nivel_d = nivel_q - LvlW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      nivel_q <= '0;
    end else begin
      mem_q   <= mem_d;
      nivel_q <= nivel_d;
    end
  end

  assign nivel_o = nivel_q;

endmodule

// File: rtl/contador_de_programa_aninhado.sv
// iZero program counter: vectors on interrupt acknowledge, restores PC from a nested return stack.
module contador_de_programa_aninhado
  import contador_de_programa_aninhado_pkg::*;
#(
  parameter int unsigned AddrW     = IzAddrW,
  parameter int unsigned Depth     = IzDepth,
  parameter int unsigned NVec      = IzNVec,
  parameter int unsigned VecBase   = IzVecBase,
  parameter int unsigned VecStride = IzVecStride
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  contador_de_programa_aninhado_if.slave bus_io
);

  localparam int unsigned VecW = idx_width(NVec);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic [AddrW-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [AddrW-1:0] top;
  logic [LvlW-1:0]  nivel;
  logic             full, empty;
  logic [VecW-1:0]  vec_idx;
  logic [AddrW-1:0] vec_addr;
  pc_act_e          act;

  assign full  = (nivel == LvlW'(Depth));
  assign empty = (nivel == '0);

  // Out-of-range indices fall back to vector 0; sum wraps modulo 2^AddrW.
  assign vec_idx  = (32'(bus_io.inta_vec) < NVec) ? bus_io.inta_vec : '0;
  assign vec_addr = AddrW'(64'(VecBase) + 64'(vec_idx) * 64'(VecStride));

  always_comb begin
    act   = ActHold;
    ovf_d = ovf_q;
    unf_d = unf_q;
    pc_d  = pc_q;
    if (bus_io.en) begin
      act   = ActNormal;
      ovf_d = ovf_q & ~bus_io.err_clr;
      unf_d = unf_q & ~bus_io.err_clr;
      // inta outranks reti; a reti coinciding with inta is dropped silently.
      if (bus_io.inta) begin
        if (!full) act = ActPush;
        else       ovf_d = 1'b1;
      end else if (bus_io.reti) begin
        if (!empty) act = ActPop;
        else        unf_d = 1'b1;
      end
    end
    unique case (act)
      ActPush:   pc_d = vec_addr;
      ActPop:    pc_d = top;
      ActNormal: pc_d = bus_io.addrin;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pilha_retorno #(
    .W     (AddrW),
    .Depth (Depth)
  ) u_pilha (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (act == ActPush),
    .pop_i   (act == ActPop),
    .data_i  (pc_q),
    .top_o   (top),
    .nivel_o (nivel)
  );

  assign bus_io.addrout  = pc_q;
  assign bus_io.addrbckp = top;
  assign bus_io.nivel    = nivel;
  assign bus_io.full     = full;
  assign bus_io.empty    = empty;
  assign bus_io.ovf      = ovf_q;
  assign bus_io.unf      = unf_q;

endmodule

// File: tb/tb_contador_de_programa_aninhado.sv
// Self-checking bench: hand-derived vector table plus stall/collision/reset sequences.
module tb_contador_de_programa_aninhado;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        inta;
    logic [1:0]  vec;
    logic        reti;
    logic        clr;
    logic [25:0] addrin;
    logic [25:0] exp_pc;
    logic [25:0] exp_bk;
    logic [2:0]  exp_n;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  contador_de_programa_aninhado_if #(
    .AddrW (26),
    .Depth (4),
    .NVec  (4)
  ) bus ();

  contador_de_programa_aninhado #(
    .AddrW     (26),
    .Depth     (4),
    .NVec      (4),
    .VecBase   (0),
    .VecStride (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
  endtask

  task automatic add(input logic rs, input logic en, input logic inta, input logic [1:0] vec,
                     input logic reti, input logic clr, input logic [25:0] ain,
                     input logic [25:0] pc, input logic [25:0] bk, input logic [2:0] n,
                     input logic ovf, input logic unf);
    vec_t v;
    v.rst_n = rs; v.en = en; v.inta = inta; v.vec = vec; v.reti = reti; v.clr = clr;
    v.addrin = ain; v.exp_pc = pc; v.exp_bk = bk; v.exp_n = n; v.exp_ovf = ovf;
    v.exp_unf = unf;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst_n        = v.rst_n;
    bus.en       = v.en;
    bus.inta     = v.inta;
    bus.inta_vec = v.vec;
    bus.reti     = v.reti;
    bus.err_clr  = v.clr;
    bus.addrin   = v.addrin;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("addrout",  idx, 32'(bus.addrout),  32'(e.exp_pc));
    check("addrbckp", idx, 32'(bus.addrbckp), 32'(e.exp_bk));
    check("nivel",    idx, 32'(bus.nivel),    32'(e.exp_n));
    check("full",     idx, 32'(bus.full),     32'(e.exp_n == 3'd4));
    check("empty",    idx, 32'(bus.empty),    32'(e.exp_n == 3'd0));
    check("ovf",      idx, 32'(bus.ovf),      32'(e.exp_ovf));
    check("unf",      idx, 32'(bus.unf),      32'(e.exp_unf));
  endtask

  task automatic step(input logic rs, input logic en, input logic inta, input logic [1:0] vec,
                      input logic reti, input logic clr, input logic [25:0] ain,
                      input logic [25:0] pc, input logic [25:0] bk, input logic [2:0] n,
                      input logic ovf, input logic unf, input int idx);
    vec_t v;
    v.rst_n = rs; v.en = en; v.inta = inta; v.vec = vec; v.reti = reti; v.clr = clr;
    v.addrin = ain; v.exp_pc = pc; v.exp_bk = bk; v.exp_n = n; v.exp_ovf = ovf;
    v.exp_unf = unf;
    apply(v, idx);
  endtask

  initial begin
    bus.en = 1'b0; bus.inta = 1'b0; bus.inta_vec = '0; bus.reti = 1'b0;
    bus.err_clr = 1'b0; bus.addrin = '0;

    //  rs en ia vec re cl addrin     pc         bckp      n  ovf unf
    add(0, 1, 0, 0, 0, 0, 26'h3FF, 26'h000, 26'h000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 26'h3FF, 26'h000, 26'h000, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 26'h100, 26'h100, 26'h000, 0, 0, 0);
    add(1, 1, 1, 2, 0, 0, 26'h104, 26'h020, 26'h100, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 26'h024, 26'h100, 26'h000, 0, 0, 0);
    // Four-deep nest, then an overflowing fifth acknowledge.
    add(1, 1, 0, 0, 0, 0, 26'h010, 26'h010, 26'h000, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 26'h0AA, 26'h000, 26'h010, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 26'h020, 26'h020, 26'h010, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0, 26'h0AA, 26'h010, 26'h020, 2, 0, 0);
    add(1, 1, 0, 0, 0, 0, 26'h030, 26'h030, 26'h020, 2, 0, 0);
    add(1, 1, 1, 3, 0, 0, 26'h0AA, 26'h030, 26'h030, 3, 0, 0);
    add(1, 1, 0, 0, 0, 0, 26'h040, 26'h040, 26'h030, 3, 0, 0);
    add(1, 1, 1, 2, 0, 0, 26'h0AA, 26'h020, 26'h040, 4, 0, 0);
    add(1, 1, 1, 1, 0, 0, 26'h044, 26'h044, 26'h040, 4, 1, 0);
    add(1, 1, 0, 0, 1, 0, 26'h099, 26'h040, 26'h030, 3, 1, 0);
    add(1, 1, 0, 0, 1, 0, 26'h099, 26'h030, 26'h020, 2, 1, 0);
    add(1, 1, 0, 0, 1, 0, 26'h099, 26'h020, 26'h010, 1, 1, 0);
    add(1, 1, 0, 0, 1, 0, 26'h099, 26'h010, 26'h000, 0, 1, 0);
    // Underflow, clear, then set-wins-over-clear.
    add(1, 1, 0, 0, 1, 0, 26'h055, 26'h055, 26'h000, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 26'h056, 26'h056, 26'h000, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 26'h057, 26'h057, 26'h000, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 26'h058, 26'h058, 26'h000, 0, 0, 0);

    foreach (tbl[i]) apply(tbl[i], i);

    // Stalled acknowledge is lost while en=0, taken exactly once when en returns.
    for (int k = 0; k < 3; k++)
      step(1, 0, 1, 1, 0, 0, 26'h077, 26'h058, 26'h000, 0, 0, 0, 100 + k);
    step(1, 1, 1, 1, 0, 0, 26'h077, 26'h010, 26'h058, 1, 0, 0, 103);
    step(1, 1, 0, 0, 0, 0, 26'h011, 26'h011, 26'h058, 1, 0, 0, 104);
    // Collision: inta wins, reti dropped without unf.
    step(1, 1, 1, 3, 1, 0, 26'h005, 26'h030, 26'h011, 2, 0, 0, 105);
    // Reset mid-nest overrides a stalled cycle and clears the stack.
    step(0, 0, 1, 2, 0, 0, 26'h123, 26'h000, 26'h000, 0, 0, 0, 106);
    step(1, 1, 1, 1, 0, 0, 26'h123, 26'h010, 26'h000, 1, 0, 0, 107);
    step(1, 1, 0, 0, 1, 0, 26'h123, 26'h000, 26'h000, 0, 0, 0, 108);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
